// File: rtl/strig_capture.sv
// Self-trigger capture: circular sample buffer and framed window readout.
// Streams HDR, LOST, winlen samples and TRL over a valid/ready port.
module strig_capture #(
  parameter int CBITS   = 9,
  parameter int TRIGLAT = 7
) (
  input  logic             adcclk,
  input  logic             reset_n,
  input  logic [15:0]      data,
  input  logic             trig,
  input  logic [9:0]       counter,
  input  logic [CBITS-1:0] pretrig,
  input  logic [CBITS-1:0] winlen,
  output logic [15:0]      dout,
  output logic             dvalid,
  input  logic             dready,
  output logic             dlast,
  output logic             busy
);

  localparam int DEPTH = 1 << CBITS;
  localparam logic [CBITS-1:0] TLAT    = CBITS'(TRIGLAT);
  localparam logic [CBITS-1:0] ONE     = CBITS'(1);
  localparam logic [CBITS-1:0] AGE_MAX = CBITS'(DEPTH - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOST, S_DATA, S_TRL, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [15:0]      mem [DEPTH];
  logic [15:0]      q;
  logic [CBITS-1:0] wa, rd, rem, age;
  logic [9:0]       cnt_l;
  logic [15:0]      lost;
  logic             ovf;
  logic             sel_mem, lost_w;
  logic [15:0]      word_r;
  logic             adv, acc, trig_lost;
  logic             iss, iss_mem, iss_last, iss_lost;
  logic [15:0]      iss_word;

  assign adv       = !dvalid || dready;
  assign acc       = dvalid && dready;
  assign busy      = state_q != S_IDLE;
  assign age       = wa - rd;
  assign trig_lost = trig && busy;
  assign dout      = sel_mem ? q : word_r;

  // q only advances when its word is taken, so a stalled sample holds
  always_ff @(posedge adcclk) begin
    if (reset_n) mem[wa] <= data;
    if (adv && iss_mem) q <= mem[rd];
  end

  always_ff @(posedge adcclk) begin
    if (!reset_n) wa <= '0;
    else          wa <= wa + ONE;
  end

  always_ff @(posedge adcclk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    iss      = 1'b0;
    iss_mem  = 1'b0;
    iss_last = 1'b0;
    iss_lost = 1'b0;
    iss_word = '0;
    unique case (state_q)
      S_IDLE: begin
        if (trig) state_d = S_HDR;
      end
      S_HDR: begin
        iss      = 1'b1;
        iss_word = {1'b1, 5'b0, cnt_l};
        if (adv) state_d = S_LOST;
      end
      S_LOST: begin
        iss      = 1'b1;
        iss_lost = 1'b1;
        iss_word = lost;
        if (adv) state_d = (rem == '0) ? S_TRL : S_DATA;
      end
      S_DATA: begin
        iss     = 1'b1;
        iss_mem = 1'b1;
        if (adv && rem == ONE) state_d = S_TRL;
      end
      S_TRL: begin
        iss      = 1'b1;
        iss_last = 1'b1;
        iss_word = {ovf, 5'b0, cnt_l};
        if (adv) state_d = S_DONE;
      end
      S_DONE: begin
        if (acc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge adcclk) begin
    if (!reset_n) begin
      rd    <= '0;
      rem   <= '0;
      cnt_l <= '0;
      ovf   <= 1'b0;
      lost  <= '0;
    end else begin
      if (state_q == S_IDLE && trig) begin
        cnt_l <= counter;
        rem   <= winlen;
        rd    <= wa - TLAT - pretrig;
      end else if (state_q == S_DATA && adv) begin
        rd  <= rd + ONE;
        rem <= rem - ONE;
      end
      if (state_q == S_DATA && age >= AGE_MAX) ovf <= 1'b1;
      else if (acc && dlast)                   ovf <= 1'b0;
      if (acc && lost_w)
        lost <= {15'b0, trig_lost};
      else if (trig_lost && lost != 16'hFFFF)
        lost <= lost + 16'd1;
    end
  end

  always_ff @(posedge adcclk) begin
    if (!reset_n) begin
      dvalid  <= 1'b0;
      dlast   <= 1'b0;
      sel_mem <= 1'b0;
      lost_w  <= 1'b0;
      word_r  <= '0;
    end else if (adv) begin
      dvalid  <= iss;
      dlast   <= iss_last;
      sel_mem <= iss_mem;
      lost_w  <= iss_lost;
      word_r  <= iss_word;
    end
  end

endmodule

// File: tb/tb_strig_capture.sv
// Bench for strig_capture: vector table, directed corner sequences and
// random traffic against an address-level buffer and packet scoreboard.
module tb_strig_capture;

  localparam int CB  = 9;
  localparam int TL  = 7;
  localparam int LIM = 3000;
  localparam logic [1:0] K_FIX = 2'd0, K_LOST = 2'd1, K_MEM = 2'd2, K_TRL = 2'd3;

  logic          adcclk = 1'b0;
  logic          reset_n, trig, dready, dvalid, dlast, busy;
  logic [15:0]   data, dout;
  logic [9:0]    counter;
  logic [CB-1:0] pretrig, winlen;

  strig_capture #(.CBITS(CB), .TRIGLAT(TL)) dut (
    .adcclk (adcclk),
    .reset_n(reset_n),
    .data   (data),
    .trig   (trig),
    .counter(counter),
    .pretrig(pretrig),
    .winlen (winlen),
    .dout   (dout),
    .dvalid (dvalid),
    .dready (dready),
    .dlast  (dlast),
    .busy   (busy)
  );

  always #5 adcclk = ~adcclk;

  typedef struct {
    logic [1:0]    kind;
    logic [15:0]   w;
    logic [CB-1:0] a;
    logic          last;
  } exp_t;

  typedef struct {
    int pre;
    int wl;
    int dm;
    int lat;
    int len;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int dmode = 0;
  int n, len;
  bit ramp = 1'b0;
  bit chk_data = 1'b1;
  logic ovf_expect = 1'b0;

  logic [15:0]   mm [1 << CB];
  logic [CB-1:0] wam = '0;
  bit            busy_m = 1'b0;
  bit            lost_pending = 1'b0;
  logic [15:0]   lost_m = '0;
  exp_t          exp_q[$];
  vec_t          vt[6];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge adcclk);
    #1;
    cyc++;
    data = ramp ? 16'(cyc) : 16'($urandom);
    case (dmode)
      0:       dready = 1'b1;
      1:       dready = !dready;
      2:       dready = ($urandom_range(0, 3) != 0);
      default: dready = 1'b0;
    endcase
  endtask

  task automatic fire();
    trig = 1'b1;
    counter = 10'($urandom);
    tick();
    trig = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy_m || exp_q.size() != 0) && k < LIM) begin
      tick();
      k++;
    end
    chk("idle_wait", 32'(k < LIM), 32'd1);
  endtask

  // Scoreboard: sampled mid-cycle, models the edge that follows.
  bit            stall_prev = 1'b0, rst_prev = 1'b0, acc_l, acc_t;
  logic [15:0]   pdout, ew;
  logic          pdlast;
  logic [CB-1:0] r0;
  exp_t          e;

  initial forever begin
    @(negedge adcclk);
    chk("busy", 32'(busy), 32'(busy_m));
    if (stall_prev) begin
      chk("hold_valid", 32'(dvalid), 32'd1);
      chk("hold_dout", 32'(dout), 32'(pdout));
      chk("hold_last", 32'(dlast), 32'(pdlast));
    end
    if (rst_prev) chk("rst_dvalid", 32'(dvalid), 32'd0);
    stall_prev = reset_n && dvalid && !dready;
    rst_prev   = !reset_n;
    pdout      = dout;
    pdlast     = dlast;
    if (!reset_n) begin
      wam = '0;
      busy_m = 1'b0;
      lost_m = '0;
      lost_pending = 1'b0;
      exp_q.delete();
    end else begin
      acc_l = 1'b0;
      acc_t = 1'b0;
      if (dvalid && dready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_word: got %0h, expected no word", dout);
        end else begin
          e  = exp_q.pop_front();
          ew = e.w;
          if (e.kind == K_MEM) ew = mm[e.a];
          if (e.kind == K_LOST) begin
            ew = lost_m;
            acc_l = 1'b1;
          end
          if (e.kind == K_TRL) acc_t = 1'b1;
          if (e.kind != K_MEM || chk_data)
            chk($sformatf("word_k%0d", e.kind), 32'(dout), 32'(ew));
          chk("dlast", 32'(dlast), 32'(e.last));
        end
      end
      if (acc_l) begin
        lost_m = (trig && busy_m) ? 16'd1 : 16'd0;
        lost_pending = 1'b0;
      end else if (trig && busy_m && lost_m != 16'hFFFF) begin
        lost_m++;
      end
      if (trig && !busy_m) begin
        r0 = wam - CB'(TL) - pretrig;
        exp_q.push_back('{K_FIX, {1'b1, 5'b0, counter}, '0, 1'b0});
        exp_q.push_back('{K_LOST, 16'h0, '0, 1'b0});
        for (int k = 0; k < int'(winlen); k++)
          exp_q.push_back('{K_MEM, 16'h0, r0 + CB'(k), 1'b0});
        exp_q.push_back('{K_TRL, {ovf_expect, 5'b0, counter}, '0, 1'b1});
        busy_m = 1'b1;
        lost_pending = 1'b1;
      end else if (acc_t) begin
        busy_m = 1'b0;
      end
      mm[wam] = data;
      wam++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{4, 8, 0, 2, 11};
    vt[1] = '{4, 8, 1, 2, 0};
    vt[2] = '{0, 0, 0, 2, 3};
    vt[3] = '{3, 1, 0, 2, 4};
    vt[4] = '{20, 33, 2, 2, 0};
    vt[5] = '{100, 60, 0, 2, 63};

    reset_n = 1'b0;
    trig = 1'b0;
    counter = '0;
    pretrig = '0;
    winlen = '0;
    dready = 1'b1;
    data = '0;
    tick();
    tick();
    chk("rst_dvalid0", 32'(dvalid), 32'd0);
    chk("rst_dlast0", 32'(dlast), 32'd0);
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_dout0", 32'(dout), 32'd0);
    reset_n = 1'b1;
    ramp = 1'b1;
    repeat (530) tick();

    for (int i = 0; i < 6; i++) begin
      pretrig = CB'(vt[i].pre);
      winlen  = CB'(vt[i].wl);
      dmode   = vt[i].dm;
      wait_idle();
      trig = 1'b1;
      counter = 10'(i * 37 + 5);
      n = 0;
      do begin
        tick();
        trig = 1'b0;
        n++;
      end while (!dvalid && n < 20);
      chk("latency", 32'(n), 32'(vt[i].lat));
      len = 1;
      while (!(dvalid && dready && dlast) && len < LIM) begin
        tick();
        len++;
      end
      if (vt[i].len != 0) chk("pkt_len", 32'(len), 32'(vt[i].len));
      tick();
      chk("busy_after", 32'(busy), 32'd0);
    end

    // lost trigger while busy, then lost landing on the LOST accept
    dmode = 0;
    pretrig = 4;
    winlen = 8;
    wait_idle();
    fire();
    repeat (5) tick();
    fire();
    wait_idle();
    fire();
    wait_idle();
    fire();
    wait_idle();
    trig = 1'b1;
    counter = 10'h2a5;
    tick();
    trig = 1'b0;
    tick();
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    wait_idle();
    fire();
    wait_idle();

    // read window wraps across address 0
    pretrig = 10;
    winlen = 24;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    fire();
    wait_idle();

    // overrun during a long stalled window
    chk_data = 1'b0;
    ovf_expect = 1'b1;
    pretrig = 490;
    winlen = 500;
    fire();
    repeat (60) tick();
    dmode = 3;
    repeat (20) tick();
    dmode = 0;
    wait_idle();
    chk_data = 1'b1;
    ovf_expect = 1'b0;
    pretrig = 4;
    winlen = 8;
    repeat (600) tick();
    fire();
    wait_idle();

    // reset mid-packet
    winlen = 40;
    fire();
    repeat (5) tick();
    fire();
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_dvalid", 32'(dvalid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    fire();
    wait_idle();

    ramp = 1'b0;
    dmode = 2;
    for (int i = 0; i < 2500; i++) begin
      trig    = !trig && !lost_pending && ($urandom_range(0, 19) == 0);
      counter = 10'($urandom);
      pretrig = CB'($urandom_range(0, 100));
      winlen  = CB'($urandom_range(0, 60));
      tick();
    end
    trig = 1'b0;
    wait_idle();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
